// File: rtl/dac_sample_pacer_pkg.sv
// Shared types and helpers for the DAC sample pacer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dac_sample_pacer_pkg;

  // Pacer FSM encoding; values are visible on o_state for debug.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } pacer_state_t;

  // Occupancy counter width: one bit wider than the pointers so DEPTH fits.
  function automatic int fill_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pacer_sync_fifo.sv
// Single-clock FIFO with flush and combinational head-of-queue data.
// Latency: a pushed word is visible at the head one clock after the push.
// Backpressure: push ignored when full, pop ignored when empty.
module pacer_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_push_data,
  input  logic                     i_pop,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [DATA_W-1:0]        o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              push_ok, pop_ok;

  assign o_full  = (level_q == LW'(DEPTH));
  assign o_empty = (level_q == '0);
  assign o_level = level_q;
  assign o_head  = mem[rd_ptr_q];

  // Guard the handshakes here so the FIFO can never over- or under-run.
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;

  // Pointer and occupancy update; flush returns everything to address 0.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge i_clk) begin
    if (push_ok && !i_flush) mem[wr_ptr_q] <= i_push_data;
  end

endmodule

// File: rtl/dac_sample_pacer.sv
// Buffers an AXI-stream of samples and releases them to a DAC at a fixed rate.
// Latency: first strobe rate_div+1 clocks after RUN entry; RUN entered once PREFILL words held.
// Backpressure: tready low when disabled, idle or full; no dependency on tvalid.
module dac_sample_pacer
  import dac_sample_pacer_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int PREFILL = 8,
  parameter int DIV_W   = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [DATA_W-1:0]           s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        i_enable,
  input  logic [DIV_W-1:0]            i_rate_div,
  input  logic                        i_clear_underflow,
  output logic [DATA_W-1:0]           o_dac_data,
  output logic                        o_dac_strobe,
  output logic [fill_w(DEPTH)-1:0]    o_fill_level,
  output logic                        o_underflow,
  output logic [1:0]                  o_state
);

  localparam int FILL_W = fill_w(DEPTH);

  pacer_state_t      state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] dac_data_q, dac_data_d;
  logic              dac_strobe_q, dac_strobe_d;
  logic              underflow_q, underflow_d;

  logic              fifo_full, fifo_empty;
  logic [FILL_W-1:0] fifo_level;
  logic [DATA_W-1:0] fifo_head;
  logic              push, pop, tick, starve, flush;

  assign s_axis_tready = i_enable && (state_q != IDLE) && !fifo_full;
  assign push          = s_axis_tvalid && s_axis_tready;

  // ">=" rather than "==" so a divider lowered below the running count still ticks next clock.
  assign tick   = i_enable && (state_q == RUN) && (cnt_q >= i_rate_div);
  assign pop    = tick && !fifo_empty;
  assign starve = tick && fifo_empty;

  // Disabling discards contents on the same edge that the FSM drops to IDLE.
  assign flush  = !i_enable || (state_q == IDLE);

  pacer_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_flush     (flush),
    .i_push      (push),
    .i_push_data (s_axis_tdata),
    .i_pop       (pop),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty),
    .o_level     (fifo_level),
    .o_head      (fifo_head)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state: enable gates everything; a starved tick falls back to priming.
  always_comb begin
    state_d = state_q;
    if (!i_enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = PRIME;
        PRIME:   if (fifo_level >= FILL_W'(PREFILL)) state_d = RUN;
        RUN:     if (starve) state_d = PRIME;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs: rate counter, registered sample/strobe and sticky underflow (set beats clear).
  always_comb begin
    cnt_d        = '0;
    dac_strobe_d = pop;
    dac_data_d   = pop ? fifo_head : dac_data_q;
    underflow_d  = underflow_q;
    if (i_enable && (state_q == RUN)) cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
    if (starve)                 underflow_d = 1'b1;
    else if (i_clear_underflow) underflow_d = 1'b0;
  end

  // Datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q        <= '0;
      dac_data_q   <= '0;
      dac_strobe_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      dac_data_q   <= dac_data_d;
      dac_strobe_q <= dac_strobe_d;
      underflow_q  <= underflow_d;
    end
  end

  assign o_dac_data   = dac_data_q;
  assign o_dac_strobe = dac_strobe_q;
  assign o_fill_level = fifo_level;
  assign o_underflow  = underflow_q;
  assign o_state      = state_q;

endmodule

// File: doc/dac_sample_pacer.md
Name: dac_sample_pacer

Overview:
Sits directly downstream of beam_mux, one instance per DAC channel. Consumes one axis_dacN stream into a small FIFO and releases samples to the DAC at a fixed programmable rate. Buffers a prefill depth before it starts streaming. Flags underflow when the FIFO runs dry mid-stream.

Parameters:
DATA_W, 32, sample width; matches beam_mux tdata
DEPTH, 16, FIFO depth in words; power of 2, >= 4
PREFILL, 8, words required before streaming starts; 1..DEPTH
DIV_W, 16, width of rate divider input

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
s_axis_tdata  in  DATA_W  sample from beam_mux axis_dacN_tdata
s_axis_tvalid  in  1  sample valid
s_axis_tready  out  1  pacer can accept; drives beam_mux axis_dacN_tready
i_enable  in  1  run enable; low = idle and flush
i_rate_div  in  DIV_W  a sample is emitted every (i_rate_div+1) clocks; 0 = every clock
i_clear_underflow  in  1  one-cycle pulse clears o_underflow
o_dac_data  out  DATA_W  registered sample to the DAC
o_dac_strobe  out  1  one-cycle pulse; o_dac_data is new this cycle
o_fill_level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
o_underflow  out  1  sticky underflow flag
o_state  out  2  current FSM state, for debug

Behaviour:
- Reset (i_rst_n low, asynchronous): all of the following are 0:
  - o_dac_data, o_dac_strobe, o_fill_level, o_underflow
  - s_axis_tready
  - rate counter, FIFO pointers
  - state = IDLE
- FIFO push: s_axis_tvalid && s_axis_tready.
  - s_axis_tready = enable && state != IDLE && fill < DEPTH. It is combinational from registered state only, with no dependency on tvalid.
  - When full, push is refused even if a pop happens in the same cycle.
  - o_fill_level reflects a push or pop one cycle after the handshake. Push and pop in the same cycle leaves the level unchanged.
- FSM states are IDLE=0, PRIME=1, RUN=2.
  - IDLE: tready low, FIFO flushed (pointers zeroed), counter 0, no strobes. Go to PRIME when i_enable=1.
  - PRIME: accepts data, no strobes, counter held at 0. Go to RUN on the cycle fill_level >= PREFILL.
  - RUN: the counter increments each clock.
    - A tick occurs when counter == i_rate_div. On a tick the counter returns to 0.
    - If the counter exceeds i_rate_div because the divider was lowered, tick on the next clock.
    - Tick with fill > 0: pop one word. o_dac_data <= the head word and o_dac_strobe = 1, both on the clock after the tick cycle.
    - Tick with fill == 0: underflow. No strobe, o_dac_data holds its last value, o_underflow <= 1, state -> PRIME.
    - There is no bypass: a word pushed in the same cycle as an empty tick does not satisfy that tick.
  - Any state: i_enable=0 forces IDLE on the next clock. Contents are discarded and o_underflow is preserved.
- First strobe after entering RUN occurs i_rate_div+1 clocks after the RUN entry edge. Strobe period is exactly i_rate_div+1 clocks while data is present.
- o_underflow: set has priority over i_clear_underflow in the same cycle. Otherwise a clear pulse drops it on the next clock.
- i_rate_div is sampled every cycle with no shadow register. Software changes it only when the block is in IDLE.
- Arithmetic:
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - The fill counter is one bit wider and saturates logically; it never wraps.
  - The counter is DIV_W bits.
- Reset asserted mid-stream clears all state immediately. The first accepted beat after release is stored at FIFO address 0.

Decomposition:
- Package dac_sample_pacer_pkg:
  - pacer_state_t enum {IDLE, PRIME, RUN}, 2-bit
  - function for fill width from DEPTH
- One sub-module: pacer_sync_fifo.
  - Parameterised DATA_W and DEPTH; async active-low reset.
  - Ports: push/pop/full/empty/level/head data.
  - Head data is available combinationally from the read pointer.
- The top holds the FSM, rate counter, output register and underflow flag.

Test Plan:
1. Reset mid-stream: drive i_rst_n low asynchronously between edges with fill=5 -> o_fill_level, o_dac_strobe, s_axis_tready and o_underflow all read 0 before the next edge. The first post-release beat 0xA5A5_0001 is the first sample out.
2. Prefill and rate: PREFILL=8, i_rate_div=3, push 0x1..0x10 back-to-back:
   - RUN is entered when fill reaches 8.
   - Strobes occur every 4 clocks, with the first 4 clocks after RUN entry.
   - o_dac_data sequence is 0x1..0x10 in order, with no gaps while data is present.
3. Backpressure: i_rate_div=15, stream 40 beats -> s_axis_tready drops when fill=16. No beat is lost or duplicated; all 40 values appear in order.
4. Underflow: i_rate_div=0, push exactly 8 beats then stop:
   - 8 strobes on consecutive clocks.
   - The next tick sets o_underflow=1 and state returns to PRIME.
   - o_dac_data holds the 8th value.
   - Clear pulse coincident with the set keeps the flag at 1; a later pulse clears it.
5. Disable flush: fill=10 in RUN, i_enable=0 for one cycle, then 1:
   - state goes IDLE -> PRIME and fill reads 0.
   - The next 8 beats stream; no old data appears.
6. Full with simultaneous tick: fill=16, tick pops while the source holds tvalid=1 -> no push that cycle (tready=0), fill=15. The push succeeds on the next cycle.
